// File: rtl/mem_stage.sv
// Memory stage of the 32-bit pipeline: EX/MEM register, word-addressed data RAM
// with range decoding, and MEM/WB register.
module mem_stage #(
    parameter int ADDR_BITS = 10
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic [31:0] RD2_ex,
    input  logic [31:0] AluResult_ex,
    input  logic        RF_WE_ex,
    input  logic        MemWE_ex,
    input  logic        WBSelect_ex,
    input  logic [3:0]  A3_ex,

    output logic [31:0] RD2_mem,
    output logic [31:0] AluResult_mem,
    output logic        RF_WE_mem,
    output logic        MemWE_mem,
    output logic        WBSelect_mem,
    output logic [3:0]  A3_mem,
    output logic [31:0] ReadData_mem,

    output logic [31:0] ReadData_wb,
    output logic [31:0] AluResult_wb,
    output logic        RF_WE_wb,
    output logic        MemWE_wb,
    output logic        WBSelect_wb,
    output logic [3:0]  A3_wb
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [31:0]          ram [0:DEPTH-1];
    logic                 in_range;
    logic [ADDR_BITS-1:0] ram_idx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RD2_mem       <= '0;
            AluResult_mem <= '0;
            RF_WE_mem     <= 1'b0;
            MemWE_mem     <= 1'b0;
            WBSelect_mem  <= 1'b0;
            A3_mem        <= '0;
        end else begin
            RD2_mem       <= RD2_ex;
            AluResult_mem <= AluResult_ex;
            RF_WE_mem     <= RF_WE_ex;
            MemWE_mem     <= MemWE_ex;
            WBSelect_mem  <= WBSelect_ex;
            A3_mem        <= A3_ex;
        end
    end

    // Addresses are word indices; anything with upper bits set falls outside the RAM.
    always_comb begin
        in_range = (AluResult_mem[31:ADDR_BITS] == '0);
        ram_idx  = AluResult_mem[ADDR_BITS-1:0];
    end

    always_comb begin
        ReadData_mem = 32'h0;
        if (in_range) begin
            ReadData_mem = ram[ram_idx];
        end
    end

    // RAM is not reset; MemWE_mem is held low by reset so no write can occur then.
    always_ff @(posedge CLK) begin
        if (MemWE_mem && in_range) begin
            ram[ram_idx] <= RD2_mem;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ReadData_wb  <= '0;
            AluResult_wb <= '0;
            RF_WE_wb     <= 1'b0;
            MemWE_wb     <= 1'b0;
            WBSelect_wb  <= 1'b0;
            A3_wb        <= '0;
        end else begin
            ReadData_wb  <= ReadData_mem;
            AluResult_wb <= AluResult_mem;
            RF_WE_wb     <= RF_WE_mem;
            MemWE_wb     <= MemWE_mem;
            WBSelect_wb  <= WBSelect_mem;
            A3_wb        <= A3_mem;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a RAM model predicts write-back results,
// queued at issue time and compared when they reach the MEM/WB register.
module tb_mem_stage;

    localparam int ADDR_BITS = 10;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    logic        CLK_tb;
    logic        RST;
    logic [31:0] RD2_ex, AluResult_ex;
    logic        RF_WE_ex, MemWE_ex, WBSelect_ex;
    logic [3:0]  A3_ex;
    logic [31:0] RD2_mem, AluResult_mem, ReadData_mem;
    logic        RF_WE_mem, MemWE_mem, WBSelect_mem;
    logic [3:0]  A3_mem;
    logic [31:0] ReadData_wb, AluResult_wb;
    logic        RF_WE_wb, MemWE_wb, WBSelect_wb;
    logic [3:0]  A3_wb;

    mem_stage #(.ADDR_BITS(ADDR_BITS)) dut (
        .CLK(CLK_tb), .RST(RST),
        .RD2_ex(RD2_ex), .AluResult_ex(AluResult_ex), .RF_WE_ex(RF_WE_ex),
        .MemWE_ex(MemWE_ex), .WBSelect_ex(WBSelect_ex), .A3_ex(A3_ex),
        .RD2_mem(RD2_mem), .AluResult_mem(AluResult_mem), .RF_WE_mem(RF_WE_mem),
        .MemWE_mem(MemWE_mem), .WBSelect_mem(WBSelect_mem), .A3_mem(A3_mem),
        .ReadData_mem(ReadData_mem),
        .ReadData_wb(ReadData_wb), .AluResult_wb(AluResult_wb), .RF_WE_wb(RF_WE_wb),
        .MemWE_wb(MemWE_wb), .WBSelect_wb(WBSelect_wb), .A3_wb(A3_wb)
    );

    initial CLK_tb = 1'b0;
    always #5 CLK_tb = ~CLK_tb;

    typedef struct {
        bit          rd_known;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [3:0]  a3;
        logic        rf_we;
        logic        mem_we;
        logic        wbs;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [int];
    bit          sb_en = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Issue one bundle at the negedge and predict its write-back result.
    task automatic drive(input logic we, input logic rfwe, input logic wbs,
                         input logic [3:0] a3, input logic [31:0] alu, input logic [31:0] rd2);
        exp_t e;
        @(negedge CLK_tb);
        MemWE_ex = we; RF_WE_ex = rfwe; WBSelect_ex = wbs;
        A3_ex = a3; AluResult_ex = alu; RD2_ex = rd2;
        e.alu = alu; e.a3 = a3; e.rf_we = rfwe; e.mem_we = we; e.wbs = wbs;
        if (alu < DEPTH) begin
            e.rd_known = model.exists(int'(alu));
            e.rd       = e.rd_known ? model[int'(alu)] : 32'h0;
            if (we) model[int'(alu)] = rd2;
        end else begin
            e.rd_known = 1'b1;
            e.rd       = 32'h0;
        end
        sb_q.push_back(e);
        @(posedge CLK_tb);
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    always @(posedge CLK_tb) begin
        exp_t e;
        #1;
        if (sb_en && sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            n_tests++;
            if ({AluResult_wb, A3_wb, RF_WE_wb, MemWE_wb, WBSelect_wb} !==
                {e.alu, e.a3, e.rf_we, e.mem_we, e.wbs}) begin
                n_fail++;
                $display("FAIL wb_ctrl alu=%h: got alu=%h a3=%h we=%b mwe=%b wbs=%b, want alu=%h a3=%h we=%b mwe=%b wbs=%b",
                         e.alu, AluResult_wb, A3_wb, RF_WE_wb, MemWE_wb, WBSelect_wb,
                         e.alu, e.a3, e.rf_we, e.mem_we, e.wbs);
            end
            if (e.rd_known) begin
                n_tests++;
                if (ReadData_wb !== e.rd) begin
                    n_fail++;
                    $display("FAIL wb_readdata addr=%h: got %h want %h", e.alu, ReadData_wb, e.rd);
                end
            end
        end
    end

    task automatic test_reset();
        sb_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_tb);
            RD2_ex = $urandom; AluResult_ex = $urandom; RF_WE_ex = 1'b1;
            MemWE_ex = 1'b0; WBSelect_ex = 1'b1; A3_ex = 4'($urandom);
        end
        @(posedge CLK_tb);
        #3;
        RST = 1'b0;
        #1;
        n_tests++;
        if ({RD2_mem, AluResult_mem, RF_WE_mem, MemWE_mem, WBSelect_mem, A3_mem} !== '0) begin
            n_fail++;
            $display("FAIL reset_async_mem: got rd2=%h alu=%h a3=%h want all 0", RD2_mem, AluResult_mem, A3_mem);
        end
        n_tests++;
        if ({ReadData_wb, AluResult_wb, RF_WE_wb, MemWE_wb, WBSelect_wb, A3_wb} !== '0) begin
            n_fail++;
            $display("FAIL reset_async_wb: got rd=%h alu=%h a3=%h want all 0", ReadData_wb, AluResult_wb, A3_wb);
        end
        @(negedge CLK_tb);
        RD2_ex = '0; AluResult_ex = '0; RF_WE_ex = 1'b0; MemWE_ex = 1'b0; WBSelect_ex = 1'b0; A3_ex = '0;
        @(negedge CLK_tb);
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK_tb);
            #1;
            n_tests++;
            if ({RD2_mem, AluResult_mem, RF_WE_mem, MemWE_mem, WBSelect_mem, A3_mem,
                 AluResult_wb, RF_WE_wb, MemWE_wb, WBSelect_wb, A3_wb} !== '0) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: got alu_mem=%h a3_mem=%h alu_wb=%h a3_wb=%h want 0",
                         i, AluResult_mem, A3_mem, AluResult_wb, A3_wb);
            end
        end
        sb_q.delete();
        sb_en = 1'b1;
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'h0, 32'(k), 32'(k));
            drive(1'b0, 1'b1, 1'b1, 4'(k), 32'(k), 32'h0);
        end
        bubble();
    endtask

    task automatic test_control();
        drive(1'b0, 1'b1, 1'b1, 4'hA, 32'h1234, 32'h0);
        n_tests++;
        if (A3_mem !== 4'hA) begin
            n_fail++;
            $display("FAIL ctrl_a3_mem: got %h want a", A3_mem);
        end
        bubble();
        n_tests++;
        if ({A3_wb, RF_WE_wb, WBSelect_wb, AluResult_wb} !== {4'hA, 1'b1, 1'b1, 32'h1234}) begin
            n_fail++;
            $display("FAIL ctrl_wb: got a3=%h we=%b wbs=%b alu=%h want a3=a we=1 wbs=1 alu=00001234",
                     A3_wb, RF_WE_wb, WBSelect_wb, AluResult_wb);
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'(DEPTH), 32'hDEADBEEF);
        drive(1'b0, 1'b1, 1'b1, 4'h1, 32'(DEPTH), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 4'h2, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h8000_0005, 32'hCAFEF00D);
        drive(1'b0, 1'b1, 1'b1, 4'h3, 32'h5, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 4'h4, 32'h8000_0005, 32'h0);
        bubble();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd7, 32'h55);
        drive(1'b0, 1'b1, 1'b1, 4'h7, 32'd7, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 4'h7, 32'd7, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd7, 32'h66);
        drive(1'b0, 1'b1, 1'b1, 4'h7, 32'd7, 32'h0);
        bubble();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd20, 32'h111);
        bubble();
        bubble();
        sb_en = 1'b0;
        sb_q.delete();
        @(negedge CLK_tb);
        MemWE_ex = 1'b1; AluResult_ex = 32'd20; RD2_ex = 32'h999; RF_WE_ex = 1'b0; WBSelect_ex = 1'b0; A3_ex = '0;
        @(posedge CLK_tb);
        #1;
        n_tests++;
        if (MemWE_mem !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_store_in_mem: got MemWE_mem=%b want 1", MemWE_mem);
        end
        #1;
        RST = 1'b0;
        #1;
        n_tests++;
        if ({MemWE_mem, AluResult_mem} !== 33'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got MemWE_mem=%b alu=%h want 0", MemWE_mem, AluResult_mem);
        end
        @(negedge CLK_tb);
        MemWE_ex = 1'b0; AluResult_ex = '0; RD2_ex = '0;
        @(negedge CLK_tb);
        RST = 1'b1;
        sb_en = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 4'h5, 32'd20, 32'h0);
        bubble();
        bubble();
    endtask

    initial begin
        RST = 1'b0;
        RD2_ex = '0; AluResult_ex = '0; RF_WE_ex = 1'b0; MemWE_ex = 1'b0; WBSelect_ex = 1'b0; A3_ex = '0;
        repeat (2) @(negedge CLK_tb);
        RST = 1'b1;
        test_reset();
        test_write_read();
        test_control();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge CLK_tb);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
